// File: rtl/coco3_ps2key_matrix.sv
// rtl/coco3_ps2key_matrix.sv - PS/2 key events to CoCo3 7x8 keyboard matrix
// Holds presses for HOLD_CYCLES, defers early releases through a small queue, flags Ctrl-Alt-Del.
module coco3_ps2key_matrix #(
  parameter int HOLD_CYCLES = 2000000,
  parameter int RELQ_DEPTH  = 4
) (
  input  logic        CLK50MHZ,
  input  logic        COCO_RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  KEY_COLUMN,
  output logic [6:0]  KEY_ROW,
  output logic        RESET_REQ,
  output logic        KEY_ACTIVE
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int CNT_W  = $clog2(RELQ_DEPTH + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  Q_FULL      = CNT_W'(RELQ_DEPTH);
  localparam logic [5:0] K_ALT  = 6'd51;
  localparam logic [5:0] K_CTRL = 6'd52;

  // Returns {hit, row*8+col}.
  function automatic logic [6:0] map_key(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = '0;
    if (ext) begin
      case (code)
        8'h75: r = {1'b1, 6'd27};
        8'h72: r = {1'b1, 6'd28};
        8'h6B: r = {1'b1, 6'd29};
        8'h74: r = {1'b1, 6'd30};
        8'h6C: r = {1'b1, 6'd49};
        8'h11: r = {1'b1, 6'd51};
        8'h14: r = {1'b1, 6'd52};
        default: r = '0;
      endcase
    end else begin
      case (code)
        8'h0E: r = {1'b1, 6'd0};  8'h1C: r = {1'b1, 6'd1};  8'h32: r = {1'b1, 6'd2};
        8'h21: r = {1'b1, 6'd3};  8'h23: r = {1'b1, 6'd4};  8'h24: r = {1'b1, 6'd5};
        8'h2B: r = {1'b1, 6'd6};  8'h34: r = {1'b1, 6'd7};  8'h33: r = {1'b1, 6'd8};
        8'h43: r = {1'b1, 6'd9};  8'h3B: r = {1'b1, 6'd10}; 8'h42: r = {1'b1, 6'd11};
        8'h4B: r = {1'b1, 6'd12}; 8'h3A: r = {1'b1, 6'd13}; 8'h31: r = {1'b1, 6'd14};
        8'h44: r = {1'b1, 6'd15}; 8'h4D: r = {1'b1, 6'd16}; 8'h15: r = {1'b1, 6'd17};
        8'h2D: r = {1'b1, 6'd18}; 8'h1B: r = {1'b1, 6'd19}; 8'h2C: r = {1'b1, 6'd20};
        8'h3C: r = {1'b1, 6'd21}; 8'h2A: r = {1'b1, 6'd22}; 8'h1D: r = {1'b1, 6'd23};
        8'h22: r = {1'b1, 6'd24}; 8'h35: r = {1'b1, 6'd25}; 8'h1A: r = {1'b1, 6'd26};
        8'h66: r = {1'b1, 6'd29}; 8'h29: r = {1'b1, 6'd31};
        8'h45: r = {1'b1, 6'd32}; 8'h16: r = {1'b1, 6'd33}; 8'h1E: r = {1'b1, 6'd34};
        8'h26: r = {1'b1, 6'd35}; 8'h25: r = {1'b1, 6'd36}; 8'h2E: r = {1'b1, 6'd37};
        8'h36: r = {1'b1, 6'd38}; 8'h3D: r = {1'b1, 6'd39}; 8'h3E: r = {1'b1, 6'd40};
        8'h46: r = {1'b1, 6'd41}; 8'h52: r = {1'b1, 6'd42}; 8'h4C: r = {1'b1, 6'd43};
        8'h41: r = {1'b1, 6'd44}; 8'h4E: r = {1'b1, 6'd45}; 8'h49: r = {1'b1, 6'd46};
        8'h4A: r = {1'b1, 6'd47}; 8'h5A: r = {1'b1, 6'd48}; 8'h76: r = {1'b1, 6'd50};
        8'h11: r = {1'b1, 6'd51}; 8'h14: r = {1'b1, 6'd52}; 8'h05: r = {1'b1, 6'd53};
        8'h06: r = {1'b1, 6'd54}; 8'h12: r = {1'b1, 6'd55}; 8'h59: r = {1'b1, 6'd55};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic [10:0]           key_q, key_d;
  logic                  ref_q, ref_d, started_q, started_d;
  logic [55:0]           mat_q, mat_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [5:0]            q_idx_q [RELQ_DEPTH];
  logic [5:0]            q_idx_d [RELQ_DEPTH];
  logic [RELQ_DEPTH-1:0] q_vld_q, q_vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [6:0]            key_row_q, key_row_d;
  logic                  reset_req_q, reset_req_d, key_active_q, key_active_d;
  logic [6:0]            hit_idx;
  logic                  evt, press_ev, rel_ev;

  always_comb begin
    key_d     = ps2_key;
    started_d = 1'b1;
    // The very first clock only seeds the reference, so a stale toggle cannot fire.
    ref_d     = started_q ? key_q[10] : ps2_key[10];
    hit_idx   = map_key(key_q[8], key_q[7:0]);
    evt       = started_q && (key_q[10] != ref_q);
    press_ev  = evt && key_q[9] && hit_idx[6];
    rel_ev    = evt && !key_q[9] && hit_idx[6];

    mat_d   = mat_q;
    q_idx_d = q_idx_q;
    q_vld_d = q_vld_q;
    cnt_d   = cnt_q;
    hold_d  = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);

    if (press_ev) begin
      for (int i = 0; i < RELQ_DEPTH; i++) begin
        if (q_idx_q[i] == hit_idx[5:0]) q_vld_d[i] = 1'b0;
      end
    end

    if (hold_q == '0 && cnt_q != '0) begin
      if (q_vld_d[0]) mat_d[q_idx_d[0]] = 1'b0;
      for (int i = 0; i < RELQ_DEPTH - 1; i++) begin
        q_idx_d[i] = q_idx_d[i+1];
        q_vld_d[i] = q_vld_d[i+1];
      end
      q_idx_d[RELQ_DEPTH-1] = '0;
      q_vld_d[RELQ_DEPTH-1] = 1'b0;
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (press_ev) begin
      mat_d[hit_idx[5:0]] = 1'b1;
      hold_d = HOLD_RELOAD;
    end else if (rel_ev && mat_q[hit_idx[5:0]]) begin
      if (hold_q == '0 && cnt_q == '0) begin
        mat_d[hit_idx[5:0]] = 1'b0;
      end else if (cnt_q != Q_FULL) begin
        for (int i = 0; i < RELQ_DEPTH; i++) begin
          if (CNT_W'(i) == cnt_d) begin
            q_idx_d[i] = hit_idx[5:0];
            q_vld_d[i] = 1'b1;
          end
        end
        cnt_d = cnt_d + CNT_W'(1);
      end else begin
        mat_d[hit_idx[5:0]] = 1'b0;
      end
    end

    reset_req_d = evt && key_q[9] && key_q[8] && (key_q[7:0] == 8'h71)
                  && mat_q[K_CTRL] && mat_q[K_ALT];
    for (int r = 0; r < 7; r++) begin
      key_row_d[r] = ~|(mat_q[r*8 +: 8] & ~KEY_COLUMN);
    end
    key_active_d = |mat_q;
  end

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      key_q        <= '0;
      ref_q        <= 1'b0;
      started_q    <= 1'b0;
      mat_q        <= '0;
      hold_q       <= '0;
      q_vld_q      <= '0;
      cnt_q        <= '0;
      key_row_q    <= 7'h7F;
      reset_req_q  <= 1'b0;
      key_active_q <= 1'b0;
      for (int i = 0; i < RELQ_DEPTH; i++) q_idx_q[i] <= '0;
    end else begin
      key_q        <= key_d;
      ref_q        <= ref_d;
      started_q    <= started_d;
      mat_q        <= mat_d;
      hold_q       <= hold_d;
      q_vld_q      <= q_vld_d;
      cnt_q        <= cnt_d;
      key_row_q    <= key_row_d;
      reset_req_q  <= reset_req_d;
      key_active_q <= key_active_d;
      for (int i = 0; i < RELQ_DEPTH; i++) q_idx_q[i] <= q_idx_d[i];
    end
  end

  assign KEY_ROW    = key_row_q;
  assign RESET_REQ  = reset_req_q;
  assign KEY_ACTIVE = key_active_q;
endmodule

// File: tb/tb_coco3_ps2key_matrix.sv
// tb/tb_coco3_ps2key_matrix.sv - self-checking bench for coco3_ps2key_matrix
// Expected values are queued with a due cycle and compared by a negedge monitor.
module tb_coco3_ps2key_matrix;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] ps2_key;
  logic [7:0]  KEY_COLUMN;
  logic [6:0]  KEY_ROW;
  logic        RESET_REQ, KEY_ACTIVE;

  coco3_ps2key_matrix #(.HOLD_CYCLES(100), .RELQ_DEPTH(4)) dut (
    .CLK50MHZ(clk), .COCO_RESET_N(rst_n), .ps2_key(ps2_key),
    .KEY_COLUMN(KEY_COLUMN), .KEY_ROW(KEY_ROW), .RESET_REQ(RESET_REQ), .KEY_ACTIVE(KEY_ACTIVE)
  );

  always #5 clk = ~clk;

  typedef struct { logic ext; logic [7:0] code; int row; int col; } map_vec_t;
  typedef struct {
    string name; int due; logic [6:0] row; logic act; logic req;
    bit c_row; bit c_act; bit c_req;
  } exp_t;

  exp_t        sb[$];
  map_vec_t    tbl[25];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tog = 1'b0;
  logic [55:0] m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].c_row) chk({sb[i].name, ".row"}, KEY_ROW, sb[i].row);
        if (sb[i].c_act) chk({sb[i].name, ".active"}, {6'd0, KEY_ACTIVE}, {6'd0, sb[i].act});
        if (sb[i].c_req) chk({sb[i].name, ".reset_req"}, {6'd0, RESET_REQ}, {6'd0, sb[i].req});
        sb.delete(i);
      end
    end
  end

  task automatic exp_row(input string name, input int d, input logic [6:0] row, input logic act);
    exp_t e;
    e.name = name; e.due = cyc + d; e.row = row; e.act = act; e.req = 1'b0;
    e.c_row = 1'b1; e.c_act = 1'b1; e.c_req = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_req(input string name, input int d, input logic req);
    exp_t e;
    e.name = name; e.due = cyc + d; e.row = 7'h7F; e.act = 1'b0; e.req = req;
    e.c_row = 1'b0; e.c_act = 1'b0; e.c_req = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic press, input logic ext, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, press, ext, code};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    m = '0;
  endtask

  function automatic logic [6:0] model_row(input logic [55:0] mm, input logic [7:0] cv);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = ~|(mm[i*8 +: 8] & ~cv);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] colv;
    logic [7:0] cols [5];
    tbl[0]  = '{1'b0, 8'h1C, 0, 1};  tbl[1]  = '{1'b0, 8'h29, 3, 7};
    tbl[2]  = '{1'b0, 8'h5A, 6, 0};  tbl[3]  = '{1'b0, 8'h76, 6, 2};
    tbl[4]  = '{1'b1, 8'h6C, 6, 1};  tbl[5]  = '{1'b1, 8'h75, 3, 3};
    tbl[6]  = '{1'b1, 8'h72, 3, 4};  tbl[7]  = '{1'b1, 8'h6B, 3, 5};
    tbl[8]  = '{1'b1, 8'h74, 3, 6};  tbl[9]  = '{1'b0, 8'h66, 3, 5};
    tbl[10] = '{1'b0, 8'h12, 6, 7};  tbl[11] = '{1'b0, 8'h59, 6, 7};
    tbl[12] = '{1'b0, 8'h14, 6, 4};  tbl[13] = '{1'b1, 8'h14, 6, 4};
    tbl[14] = '{1'b0, 8'h11, 6, 3};  tbl[15] = '{1'b1, 8'h11, 6, 3};
    tbl[16] = '{1'b0, 8'h05, 6, 5};  tbl[17] = '{1'b0, 8'h06, 6, 6};
    tbl[18] = '{1'b0, 8'h15, 2, 1};  tbl[19] = '{1'b0, 8'h45, 4, 0};
    tbl[20] = '{1'b0, 8'h46, 5, 1};  tbl[21] = '{1'b0, 8'h4A, 5, 7};
    tbl[22] = '{1'b0, 8'h1A, 3, 2};  tbl[23] = '{1'b0, 8'h7E, -1, -1};
    tbl[24] = '{1'b1, 8'h70, -1, -1};
    cols[0] = 8'hFF; cols[1] = 8'h00; cols[2] = 8'h7F; cols[3] = 8'hFE; cols[4] = 8'h5A;

    rst_n = 1'b0; ps2_key = '0; KEY_COLUMN = 8'h00; m = '0;
    tick(2);
    chk("reset.row", KEY_ROW, 7'h7F);
    chk("reset.active", {6'd0, KEY_ACTIVE}, 7'd0);
    chk("reset.reset_req", {6'd0, RESET_REQ}, 7'd0);
    rst_n = 1'b1;
    tick(2);

    // key map: keys accumulate; each is observed through its own column strobe
    for (int i = 0; i < 25; i++) begin
      send(1'b1, tbl[i].ext, tbl[i].code);
      if (tbl[i].row >= 0) begin
        m[tbl[i].row*8 + tbl[i].col] = 1'b1;
        colv = ~(8'h01 << tbl[i].col);
      end else begin
        colv = 8'h00;
      end
      KEY_COLUMN = colv;
      exp_row($sformatf("map[%0d]", i), 3, model_row(m, colv), |m);
      tick(3);
    end
    for (int i = 0; i < 5; i++) begin
      KEY_COLUMN = cols[i];
      exp_row($sformatf("colscan[%0d]", i), 1, model_row(m, cols[i]), 1'b1);
      tick(1);
    end

    // press latency and column change
    do_reset();
    KEY_COLUMN = 8'hFD;
    send(1'b1, 1'b0, 8'h1C);
    exp_row("latency.early", 2, 7'h7F, 1'b0);
    exp_row("latency.n2", 3, 7'h7E, 1'b1);
    tick(3);
    KEY_COLUMN = 8'hFE;
    exp_row("colchange", 1, 7'h7F, 1'b1);
    tick(2);

    // short press held until the hold window expires
    do_reset();
    KEY_COLUMN = 8'hFD;
    send(1'b1, 1'b0, 8'h1C);
    tick(10);
    send(1'b0, 1'b0, 8'h1C);
    exp_row("hold.last", 92, 7'h7E, 1'b1);
    exp_row("hold.cleared", 93, 7'h7F, 1'b0);
    tick(94);

    // re-press invalidates the queued release
    do_reset();
    KEY_COLUMN = 8'hF7;
    send(1'b1, 1'b1, 8'h75);
    exp_row("up.press", 3, 7'h77, 1'b1);
    tick(5);
    send(1'b0, 1'b1, 8'h75);
    tick(5);
    send(1'b1, 1'b1, 8'h75);
    exp_row("up.invalidated", 140, 7'h77, 1'b1);
    tick(140);
    send(1'b0, 1'b1, 8'h75);
    exp_row("up.immediate_release", 3, 7'h7F, 1'b0);
    tick(4);

    // queue overflow and consecutive pops
    do_reset();
    KEY_COLUMN = 8'hFF;
    send(1'b1, 1'b0, 8'h1C); tick(1);
    send(1'b1, 1'b0, 8'h32); tick(1);
    send(1'b1, 1'b0, 8'h21); tick(1);
    send(1'b1, 1'b0, 8'h23); tick(1);
    send(1'b1, 1'b0, 8'h24); tick(1);
    send(1'b0, 1'b0, 8'h1C); tick(1);
    send(1'b0, 1'b0, 8'h32); tick(1);
    send(1'b0, 1'b0, 8'h21); tick(1);
    send(1'b0, 1'b0, 8'h23); tick(1);
    send(1'b0, 1'b0, 8'h24); tick(1);
    KEY_COLUMN = 8'hDF;
    exp_row("qfull.e_before", 1, 7'h7E, 1'b1);
    exp_row("qfull.e_cleared", 2, 7'h7F, 1'b1);
    tick(2);
    KEY_COLUMN = 8'hE1;
    exp_row("qfull.a_to_d_held", 1, 7'h7E, 1'b1);
    tick(93);
    KEY_COLUMN = 8'hFD; exp_row("pop.a_last", 1, 7'h7E, 1'b1); tick(1);
    KEY_COLUMN = 8'hFB; exp_row("pop.b_last", 1, 7'h7E, 1'b1); tick(1);
    KEY_COLUMN = 8'hF7; exp_row("pop.c_last", 1, 7'h7E, 1'b1); tick(1);
    KEY_COLUMN = 8'hEF;
    exp_row("pop.d_last", 1, 7'h7E, 1'b1);
    exp_row("pop.d_cleared", 2, 7'h7F, 1'b0);
    tick(3);

    // Ctrl-Alt-Del
    do_reset();
    KEY_COLUMN = 8'h00;
    send(1'b1, 1'b0, 8'h14); tick(1);
    send(1'b1, 1'b0, 8'h11); tick(1);
    send(1'b1, 1'b1, 8'h71);
    exp_req("cad.n", 1, 1'b0);
    exp_req("cad.pulse", 2, 1'b1);
    exp_req("cad.one_cycle", 3, 1'b0);
    exp_row("cad.no_bit", 3, 7'h3F, 1'b1);
    tick(4);
    do_reset();
    send(1'b1, 1'b0, 8'h11); tick(1);
    send(1'b1, 1'b1, 8'h71);
    exp_req("noctrl.n1", 2, 1'b0);
    exp_req("noctrl.n2", 3, 1'b0);
    exp_row("noctrl.row", 3, 7'h3F, 1'b1);
    tick(4);

    // asynchronous reset with pending releases
    do_reset();
    KEY_COLUMN = 8'h00;
    if (!tog) begin
      send(1'b1, 1'b0, 8'h7E);
      tick(1);
    end
    send(1'b1, 1'b0, 8'h12); tick(1);
    send(1'b1, 1'b0, 8'h1C); tick(1);
    send(1'b1, 1'b0, 8'h32); tick(1);
    send(1'b0, 1'b0, 8'h1C); tick(1);
    send(1'b0, 1'b0, 8'h32);
    exp_row("areset.before", 1, 7'h3E, 1'b1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.row_now", KEY_ROW, 7'h7F);
    chk("areset.active_now", {6'd0, KEY_ACTIVE}, 7'd0);
    send(1'b1, 1'b0, 8'h1C);
    tick(2);
    rst_n = 1'b1;
    exp_row("areset.first_clock", 3, 7'h7F, 1'b0);
    exp_row("areset.queue_gone", 120, 7'h7F, 1'b0);
    tick(121);
    send(1'b1, 1'b0, 8'h32);
    exp_row("areset.alive", 3, 7'h7E, 1'b1);
    tick(5);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
